// File: rtl/shift_chain_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : shift_chain_pkg
// Description : Shared types and helpers for the shift-chain sequencer:
//               FSM state encoding, one-hot grant encodings, chain-width and
//               bit-counter-width helpers.
// Config      : SHIFT_CHAIN_PARITY_EN - when defined the chain is one bit
//               wider than the data word (trailing even-parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_chain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_A    = 2'b01;
  localparam logic [1:0] GRANT_B    = 2'b10;

  // Number of bits shifted per transfer for a given data width.
  function automatic int chain_width(input int width);
`ifdef SHIFT_CHAIN_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Counter must be able to hold the value cw itself so it never wraps.
  function automatic int cnt_width(input int cw);
    return $clog2(cw + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_chain_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : shift_chain_sequencer_if
// Description : Request/data bundle from the two requesters and the status /
//               chain outputs of the sequencer.
// Ports       : req_a/data_a, req_b/data_b (requester side drives),
//               q (CW bits), busy, done, grant (2b one-hot), ser.
// Modports    : master - requester / observer side
//               slave  - sequencer side
// Config      : SHIFT_CHAIN_PARITY_EN widens q by one bit.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_chain_sequencer_if #(
  parameter int WIDTH = 8
);
  import shift_chain_pkg::*;

  localparam int c_cw = chain_width(WIDTH);

  logic             input_push_button3_req_a_3;
  logic [WIDTH-1:0] input_switch4_data_a_4;
  logic             input_push_button5_req_b_5;
  logic [WIDTH-1:0] input_switch6_data_b_6;
  logic [c_cw-1:0]  output_led1_q_7;
  logic             output_led2_busy_8;
  logic             output_led3_done_9;
  logic [1:0]       output_led4_grant_10;
  logic             output_led5_ser_11;

  modport master (
    output input_push_button3_req_a_3, input_switch4_data_a_4,
    output input_push_button5_req_b_5, input_switch6_data_b_6,
    input  output_led1_q_7, output_led2_busy_8, output_led3_done_9,
    input  output_led4_grant_10, output_led5_ser_11
  );

  modport slave (
    input  input_push_button3_req_a_3, input_switch4_data_a_4,
    input  input_push_button5_req_b_5, input_switch6_data_b_6,
    output output_led1_q_7, output_led2_busy_8, output_led3_done_9,
    output output_led4_grant_10, output_led5_ser_11
  );

endinterface
`default_nettype wire

// File: rtl/shift_chain_sequencer_dff_chain.sv
`default_nettype none
// ============================================================================
// Module      : dff_chain
// Description : CW-stage D flip-flop shift chain. Bits enter at stage 0 and
//               move toward the MSB on each enabled edge.
// Ports       : clk        - clock
//               i_clr      - synchronous clear (priority over shift)
//               i_shift_en - shift enable
//               i_ser      - serial input into stage 0
//               o_q        - parallel chain contents
// Revision    : 1.0 - initial release
// ============================================================================
module dff_chain #(
  parameter int CW = 8
) (
  input  wire          clk,
  input  wire          i_clr,
  input  wire          i_shift_en,
  input  wire          i_ser,
  output wire [CW-1:0] o_q
);

  // D input of every stage: stage 0 takes the serial bit, stage i takes i-1.
  wire [CW-1:0] w_d;
  assign w_d = {o_q[CW-2:0], i_ser};

  generate
    for (genvar gi = 0; gi < CW; gi++) begin : g_stage
      // Master-slave D flip-flop: the master/slave latch pair is expressed
      // as its edge-triggered equivalent, with hold when not enabled.
      logic r_bit;
      always_ff @(posedge clk) begin
        if (i_clr) begin
          r_bit <= 1'b0;
        end else if (i_shift_en) begin
          r_bit <= w_d[gi];
        end
      end
      assign o_q[gi] = r_bit;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/shift_chain_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_chain_sequencer
// Description : Round-robin arbiter for two requesters that serialises the
//               winner's word MSB-first into a D flip-flop chain, then pulses
//               done for one cycle.
// Ports       : input_clock1_clk_1       - clock (rising edge)
//               input_push_button2_rst_2 - synchronous active-high reset
//               bus (slave)              - requests, data words, q, busy,
//                                          done, grant, ser
// Config      : SHIFT_CHAIN_PARITY_EN - append even parity of the captured
//               word as one extra trailing shift (CW = WIDTH+1).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_chain_sequencer
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input wire                     input_clock1_clk_1,
  input wire                     input_push_button2_rst_2,
  shift_chain_sequencer_if.slave bus
);

  localparam int c_cw    = chain_width(WIDTH);
  localparam int c_cnt_w = cnt_width(c_cw);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_cw - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  state_t              r_state;
  logic [c_cw-1:0]     r_hold;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_last_b;
  logic [1:0]          r_grant;
  logic                r_busy;
  logic                r_done;

  logic                w_any_req;
  logic                w_pick_b;
  logic [WIDTH-1:0]    w_win_data;
  logic [1:0]          w_win_grant;
  logic [c_cw-1:0]     w_word_ext;
  logic [c_cw-1:0]     w_q;
  logic                w_shift_en;

  // B wins when it is the only requester, or when both request and A was
  // the one served last.
  assign w_any_req   = bus.input_push_button3_req_a_3 | bus.input_push_button5_req_b_5;
  assign w_pick_b    = bus.input_push_button5_req_b_5 &
                       (~bus.input_push_button3_req_a_3 | ~r_last_b);
  assign w_win_data  = w_pick_b ? bus.input_switch6_data_b_6 : bus.input_switch4_data_a_4;
  assign w_win_grant = w_pick_b ? GRANT_B : GRANT_A;

`ifdef SHIFT_CHAIN_PARITY_EN
  assign w_word_ext = {w_win_data, ^w_win_data};
`else
  assign w_word_ext = w_win_data;
`endif

  always_ff @(posedge input_clock1_clk_1) begin
    if (input_push_button2_rst_2) begin
      r_state  <= ST_IDLE;
      r_hold   <= '0;
      r_cnt    <= '0;
      r_last_b <= 1'b1;
      r_grant  <= GRANT_NONE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_hold  <= w_word_ext;
            r_grant <= w_win_grant;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The holding register drains MSB-first; once empty it reads 0,
          // which keeps the serial output low outside of a transfer.
          r_hold <= {r_hold[c_cw-2:0], 1'b0};
          r_cnt  <= r_cnt + c_one;
          if (r_cnt == c_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done   <= 1'b0;
          r_last_b <= (r_grant == GRANT_B);
          r_grant  <= GRANT_NONE;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_shift_en = (r_state == ST_SHIFT);

  dff_chain #(
    .CW (c_cw)
  ) u_chain (
    .clk        (input_clock1_clk_1),
    .i_clr      (input_push_button2_rst_2),
    .i_shift_en (w_shift_en),
    .i_ser      (r_hold[c_cw-1]),
    .o_q        (w_q)
  );

  assign bus.output_led1_q_7      = w_q;
  assign bus.output_led2_busy_8   = r_busy;
  assign bus.output_led3_done_9   = r_done;
  assign bus.output_led4_grant_10 = r_grant;
  assign bus.output_led5_ser_11   = r_hold[c_cw-1];

endmodule
`default_nettype wire

// File: tb/tb_shift_chain_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_chain_sequencer
// Description : Self-checking bench for shift_chain_sequencer (WIDTH = 8).
//               A transfer-level reference model predicts every output each
//               cycle; directed scenarios add hand-computed literal checks.
// Config      : SHIFT_CHAIN_PARITY_EN adds the parity scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_chain_sequencer;

  localparam int WIDTH = 8;
`ifdef SHIFT_CHAIN_PARITY_EN
  localparam int CW = WIDTH + 1;
`else
  localparam int CW = WIDTH;
`endif

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  shift_chain_sequencer_if #(.WIDTH(WIDTH)) bus ();

  shift_chain_sequencer #(.WIDTH(WIDTH)) dut (
    .input_clock1_clk_1       (clk),
    .input_push_button2_rst_2 (rst),
    .bus                      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Word as it is shifted: data word, plus trailing parity when enabled.
  function automatic logic [CW-1:0] ext(input logic [WIDTH-1:0] w);
`ifdef SHIFT_CHAIN_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // ---------------- transfer-level reference model ----------------
  // m_t counts edges since the grant edge: 0..CW-1 shifting, CW = done cycle.
  bit            m_valid = 0;
  bit            m_active;
  bit            m_last_b;
  int            m_t;
  logic [1:0]    m_g;
  logic [CW-1:0] m_word, m_q, m_q0;
  bit            pick_b;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_active = 0; m_last_b = 1; m_t = 0; m_g = 2'b00; m_q = '0;
    end else if (m_active) begin
      m_t++;
      if (m_t > CW) begin
        m_active = 0;
        m_last_b = (m_g == 2'b10);
        m_g      = 2'b00;
        m_q      = m_word;
      end
    end else if (bus.input_push_button3_req_a_3 || bus.input_push_button5_req_b_5) begin
      pick_b   = bus.input_push_button5_req_b_5 && (!bus.input_push_button3_req_a_3 || !m_last_b);
      m_word   = ext(pick_b ? bus.input_switch6_data_b_6 : bus.input_switch4_data_a_4);
      m_g      = pick_b ? 2'b10 : 2'b01;
      m_q0     = m_q;
      m_t      = 0;
      m_active = 1;
    end
  end

  logic [CW-1:0] e_q;
  logic          e_busy, e_done, e_ser;
  logic [1:0]    e_grant;

  always @(negedge clk) begin
    if (m_valid) begin
      if (m_active && m_t < CW) begin
        // After m_t shifts the top m_t word bits sit at the chain bottom.
        e_busy = 1; e_done = 0; e_grant = m_g;
        e_ser  = m_word[CW-1-m_t];
        e_q    = (m_q0 << m_t) | (m_word >> (CW - m_t));
      end else if (m_active) begin
        e_busy = 0; e_done = 1; e_grant = m_g; e_ser = 0; e_q = m_word;
      end else begin
        e_busy = 0; e_done = 0; e_grant = 2'b00; e_ser = 0; e_q = m_q;
      end
      check("cyc_q",     bus.output_led1_q_7,      e_q);
      check("cyc_busy",  bus.output_led2_busy_8,   e_busy);
      check("cyc_done",  bus.output_led3_done_9,   e_done);
      check("cyc_grant", bus.output_led4_grant_10, e_grant);
      check("cyc_ser",   bus.output_led5_ser_11,   e_ser);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int n_busy;
  int n_done;

  initial begin
    rst = 1'b1;
    bus.input_push_button3_req_a_3 = 1'b0;
    bus.input_push_button5_req_b_5 = 1'b0;
    bus.input_switch4_data_a_4     = '0;
    bus.input_switch6_data_b_6     = '0;
    tick(); tick();
    check("rst_q",     bus.output_led1_q_7, 0);
    check("rst_busy",  bus.output_led2_busy_8, 0);
    check("rst_done",  bus.output_led3_done_9, 0);
    check("rst_grant", bus.output_led4_grant_10, 0);
    check("rst_ser",   bus.output_led5_ser_11, 0);
    rst = 1'b0;
    repeat (5) tick();
    check("idle_q",    bus.output_led1_q_7, 0);
    check("idle_busy", bus.output_led2_busy_8, 0);

    // Single A transfer of 0xA5.
    bus.input_push_button3_req_a_3 = 1'b1;
    bus.input_switch4_data_a_4     = 8'hA5;
    tick();                                        // E0
    check("a5_grant", bus.output_led4_grant_10, 2'b01);
    check("a5_ser0",  bus.output_led5_ser_11, 1'b1);
    bus.input_push_button3_req_a_3 = 1'b0;
    n_busy = int'(bus.output_led2_busy_8);
    repeat (CW - 1) begin
      tick();
      n_busy += int'(bus.output_led2_busy_8);
    end
    tick();                                        // E_CW
    check("a5_busy_cycles", n_busy, CW);
    check("a5_q",    bus.output_led1_q_7, ext(8'hA5));
    check("a5_done", bus.output_led3_done_9, 1'b1);
    check("a5_busy_end", bus.output_led2_busy_8, 1'b0);
    tick();
    check("a5_done_off",  bus.output_led3_done_9, 1'b0);
    check("a5_grant_off", bus.output_led4_grant_10, 2'b00);

    // Both requesting after reset: A first, then B at E_CW+2.
    rst = 1'b1; tick(); rst = 1'b0;
    bus.input_push_button3_req_a_3 = 1'b1;
    bus.input_push_button5_req_b_5 = 1'b1;
    bus.input_switch4_data_a_4     = 8'h3C;
    bus.input_switch6_data_b_6     = 8'hC3;
    tick();                                        // E0
    check("rr_first_grant", bus.output_led4_grant_10, 2'b01);
    repeat (CW) tick();                            // E_CW
    check("rr_a_q", bus.output_led1_q_7, ext(8'h3C));
    tick();                                        // E_CW+1
    check("rr_gap_grant", bus.output_led4_grant_10, 2'b00);
    tick();                                        // E_CW+2
    check("rr_second_grant", bus.output_led4_grant_10, 2'b10);
    bus.input_push_button3_req_a_3 = 1'b0;
    bus.input_push_button5_req_b_5 = 1'b0;
    repeat (CW) tick();
    check("rr_b_q",    bus.output_led1_q_7, ext(8'hC3));
    check("rr_b_done", bus.output_led3_done_9, 1'b1);
    tick();

    // Data change mid-transfer must not disturb it (A wins: B served last).
    bus.input_push_button3_req_a_3 = 1'b1;
    bus.input_switch4_data_a_4     = 8'hA5;
    tick();                                        // E0
    bus.input_push_button3_req_a_3 = 1'b0;
    tick(); tick();                                // E1, E2
    bus.input_switch4_data_a_4     = 8'h00;        // sampled from E3
    repeat (CW - 2) tick();                        // E_CW
    check("hold_q", bus.output_led1_q_7, ext(8'hA5));
    tick();

    // Reset at E4 of a 0xFF transfer aborts it without a done pulse.
    bus.input_push_button3_req_a_3 = 1'b1;
    bus.input_switch4_data_a_4     = 8'hFF;
    tick();                                        // E0
    bus.input_push_button3_req_a_3 = 1'b0;
    repeat (3) tick();                             // E3
    rst = 1'b1;
    tick();                                        // E4
    check("abort_q",     bus.output_led1_q_7, 0);
    check("abort_busy",  bus.output_led2_busy_8, 0);
    check("abort_grant", bus.output_led4_grant_10, 0);
    rst = 1'b0;
    n_done = 0;
    repeat (CW + 2) begin
      tick();
      n_done += int'(bus.output_led3_done_9);
    end
    check("abort_no_done", n_done, 0);

    // B alone wins.
    bus.input_push_button5_req_b_5 = 1'b1;
    bus.input_switch6_data_b_6     = 8'h5A;
    tick();
    check("b_only_grant", bus.output_led4_grant_10, 2'b10);
    bus.input_push_button5_req_b_5 = 1'b0;
    repeat (CW) tick();
    check("b_only_q", bus.output_led1_q_7, ext(8'h5A));
    tick();

`ifdef SHIFT_CHAIN_PARITY_EN
    rst = 1'b1; tick(); rst = 1'b0;
    bus.input_push_button3_req_a_3 = 1'b1;
    bus.input_switch4_data_a_4     = 8'h07;
    tick();                                        // E0
    bus.input_push_button3_req_a_3 = 1'b0;
    repeat (9) tick();                             // E9
    check("par_q",    bus.output_led1_q_7, 9'b0_0000_1111);
    check("par_done", bus.output_led3_done_9, 1'b1);
    tick();
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
